// File: rtl/midi_uart_rx_mmio_pkg.sv
// MIDI receiver shared types: FSM encoding, register map, status bits.
package midi_uart_rx_mmio_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    localparam logic [31:0] REG_DATA   = 32'd0;
    localparam logic [31:0] REG_STATUS = 32'd1;

    localparam int ST_NE   = 0;
    localparam int ST_FERR = 1;
    localparam int ST_OVR  = 2;

    localparam int OVS = 16;
endpackage

// File: rtl/midi_uart_rx_mmio_if.sv
// dmem-side register bus between the memory stage and the MIDI receiver.
interface midi_uart_rx_mmio_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        wren;
    logic        rd_en;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output address, wdata, wren, rd_en,
        input  sel, rdata
    );

    modport slave (
        input  address, wdata, wren, rd_en,
        output sel, rdata
    );
endinterface

// File: rtl/midi_uart_rx_mmio_sync_byte_fifo.sv
// Byte FIFO with combinational head; push+pop allowed at any occupancy.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/midi_uart_rx_mmio.sv
// MIDI 8N1 serial receiver with a byte FIFO exposed as DATA/STATUS registers.
import midi_uart_rx_mmio_pkg::*;

module midi_uart_rx_mmio #(
    parameter int          CLK_HZ     = 50000000,
    parameter int          BAUD       = 31250,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  midi_rx,
    midi_uart_rx_mmio_if.slave    bus,
    output logic                  irq
);
    localparam int DIV = CLK_HZ / (BAUD * OVS);
    localparam int DW  = $clog2(DIV + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    rx_state_t     state, state_n;
    logic          rx_meta, rx_sync, rx_prev;
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick, fall, phase_end;
    logic          enter_start, sample, push_req, ferr_set;
    logic          ovr, ferr, ovr_set, ovr_clr, ferr_clr;
    logic          hit_data, hit_status, pop;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic [8:0]    cnt_ext;
    logic          full, empty;
    logic          unused_bits;

    assign tick      = (div_cnt == DW'(DIV - 1));
    assign fall      = rx_prev & ~rx_sync;
    assign phase_end = tick && (tick_cnt ==
                       ((state == S_START) ? 4'(OVS/2 - 1) : 4'(OVS - 1)));

    always_comb begin
        state_n     = state;
        enter_start = 1'b0;
        sample      = 1'b0;
        push_req    = 1'b0;
        ferr_set    = 1'b0;
        unique case (state)
            S_IDLE: if (fall) begin
                state_n     = S_START;
                enter_start = 1'b1;
            end
            S_START: if (phase_end) begin
                state_n = rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: if (phase_end) begin
                sample = 1'b1;
                if (bit_idx == 3'd7) state_n = S_STOP;
            end
            S_STOP: if (phase_end) begin
                push_req = rx_sync;
                ferr_set = ~rx_sync;
                state_n  = S_IDLE;
            end
        endcase
    end

    assign hit_data   = (bus.address == BASE_ADDR + REG_DATA);
    assign hit_status = (bus.address == BASE_ADDR + REG_STATUS);
    assign bus.sel    = hit_data | hit_status;
    assign pop        = bus.rd_en & hit_data & ~empty;
    assign ovr_set    = push_req & full & ~pop;
    assign ovr_clr    = bus.wren & hit_status & bus.wdata[ST_OVR];
    assign ferr_clr   = bus.wren & hit_status & bus.wdata[ST_FERR];
    assign cnt_ext    = 9'(count);
    assign unused_bits = ^{bus.wdata[31:3], bus.wdata[0], cnt_ext[8]};

    always_comb begin
        bus.rdata = '0;
        unique case (1'b1)
            hit_data:   bus.rdata = empty ? 32'd0 : {23'b0, 1'b1, head};
            hit_status: bus.rdata = {16'b0, cnt_ext[7:0], 5'b0, ovr, ferr, ~empty};
            default:    bus.rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state   <= state_n;
            rx_meta <= midi_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            div_cnt <= (enter_start || tick) ? '0 : div_cnt + 1'b1;
            if (enter_start || phase_end) tick_cnt <= '0;
            else if (tick)                tick_cnt <= tick_cnt + 1'b1;
            if (enter_start) bit_idx <= '0;
            else if (sample) bit_idx <= bit_idx + 1'b1;
            if (sample) shreg <= {rx_sync, shreg[7:1]};
            // Same-cycle set beats the write-1-to-clear.
            ovr  <= ovr_set  | (ovr  & ~ovr_clr);
            ferr <= ferr_set | (ferr & ~ferr_clr);
            irq  <= (count != '0);
        end
    end

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .din   (shreg),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: doc/midi_uart_rx_mmio.md
Name: midi_uart_rx_mmio

Overview:
- MIDI serial receiver (31250 baud, 8N1) with a receive FIFO.
- Exposes the FIFO to the processor as memory-mapped registers on the dmem bus.
- Sits directly downstream of the processor's memory stage. It decodes address_dmem, wren and a read strobe, and returns read data that is muxed into q_dmem.
- Firmware polls or takes an interrupt to pull note bytes for the synth voices.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- FIFO_DEPTH, 16, byte entries; must be a power of two, 2 to 256.
- BASE_ADDR, 32'h0000_1000, word address of the DATA register. STATUS is at BASE_ADDR+1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- midi_rx  in  1  asynchronous serial input; idles high.
- address  in  32  word address from the processor's memory stage.
- wdata  in  32  store data from the processor.
- wren  in  1  store strobe, one cycle per store.
- rd_en  in  1  load strobe (memory-stage use_mem and not wren), one cycle per load.
- sel  out  1  combinational; high when address equals BASE_ADDR or BASE_ADDR+1.
- rdata  out  32  combinational read data. Zero when sel is low.
- irq  out  1  registered; high while the FIFO is non-empty.

Behaviour:
- Reset: FIFO empty, count=0, flags cleared, FSM in IDLE, synchronizer flops set to 1. Outputs after reset: irq=0; rdata=0 for any address.
- Input path: 2-flop synchronizer on midi_rx.
- Oversample tick: asserted every DIV = CLK_HZ/(BAUD*16) clocks (100 at defaults). The divider counter resets to 0 on entry to START.
- FSM, IDLE: on a synced 1->0 transition, go to START.
- FSM, START: after 8 ticks, sample the line. If low, go to DATA. If high, the event is a glitch: return to IDLE with nothing recorded.
- FSM, DATA: sample every 16 ticks; 8 bits, LSB first, shifted into the byte register.
- FSM, STOP: after 16 ticks, sample the line.
  - Stop bit high: push the byte. If the FIFO is full and no pop occurs this cycle, drop the byte and set OVR.
  - Stop bit low: set FERR and discard the byte.
  - Either way, return to IDLE. A new start is accepted on the next cycle.
- DATA register, read: rdata = {23'b0, nonempty, head_byte}. If non-empty, the head pops at the clock edge ending the rd_en cycle. If empty, rdata = 0 and there is no pop.
- DATA register, write: ignored.
- STATUS register, read: rdata = {16'b0, count[7:0], 5'b0, OVR, FERR, nonempty}. Has no side effects.
- STATUS register, write: write-1-to-clear. wdata[2] clears OVR; wdata[1] clears FERR. If a set and a clear of the same flag occur in the same cycle, the set wins.
- rd_en or wren with sel low: no effect.
- Push and pop in the same cycle: both happen and count is unchanged. When the FIFO is full, the simultaneous push is accepted and OVR is not set.
- Pointers: log2(FIFO_DEPTH) bits, naturally wrapping. count is log2(FIFO_DEPTH)+1 bits.
- irq: registered copy of (count != 0) taken at each edge, so it follows count by one cycle.
- Reset mid-frame: the partial byte is discarded and FSM returns to IDLE. A frame that begins afterwards is received normally.
- Latency: a byte is visible in the FIFO on the clock cycle after the stop-bit sample.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, DATA, STOP), register offsets (DATA=0, STATUS=1), STATUS bit positions (NE=0, FERR=1, OVR=2), oversample factor 16.
- One sub-module, sync_byte_fifo.
  - Parameter: DEPTH.
  - Ports: clock, reset, push, din, pop, dout, count, full, empty.
  - Behaviour: head is readable combinationally; push and pop in the same cycle are allowed at any occupancy.

Test Plan:
- Byte reception: drive one frame of 0x90 at 31250 baud.
  - STATUS then reads 0x0000_0101.
  - A DATA read returns 0x0000_0190.
  - STATUS then reads 0x0000_0000 and irq drops one cycle later.
- Glitch rejection: a 3 us low pulse on an idle line leaves count=0 and FERR=0. A following frame of 0x3C is received intact.
- Framing error: frame 0x45 with the stop bit held low.
  - STATUS reads 0x0000_0002 and count=0.
  - A store of 0x2 to STATUS clears it back to 0.
- Overflow: send 17 bytes 0x00..0x10 without reading.
  - STATUS reads 0x0000_1005.
  - Sixteen DATA reads return 0x100..0x10F in order.
  - A seventeenth read returns 0.
- Full FIFO, simultaneous events: with 16 entries held, assert rd_en on DATA in the same cycle as a stop-bit push of 0xAA.
  - count stays 16 and OVR stays 0.
  - The last entry read back is 0x1AA.
- Reset mid-frame: assert reset during data bit 4 of a frame.
  - Afterwards count=0, irq=0 and the FSM is in IDLE.
  - The next full frame of 0x7F reads back as 0x17F.
